// File: rtl/fifo_param.sv
// -----------------------------------------------------------------------------
// fifo_param
//
// Parametrised single-clock synchronous FIFO. It sits between a producer and a
// consumer datapath stage in the same clock domain.
//
// Features:
//   - WIDTH-bit words, DEPTH = 2**DEPTH_LOG2 entries.
//   - Occupancy count (0..DEPTH).
//   - Almost-full flag  (Count >= AF_LEVEL).
//   - Almost-empty flag (Count <= AE_LEVEL).
//   - Sticky overflow and underflow error flags, cleared by Clr_err.
//   - Two read modes, selected by FWFT:
//       FWFT = 0 : registered read. Dout is loaded on an accepted read and
//                  Dvalid pulses for exactly the following cycle.
//       FWFT = 1 : first-word-fall-through. Dout always shows the head entry
//                  and Dvalid = ~Fempty.
//
// Parameters:
//   WIDTH      data word width in bits
//   DEPTH_LOG2 log2 of the number of entries
//   AF_LEVEL   almost-full threshold,  legal range 1..DEPTH
//   AE_LEVEL   almost-empty threshold, legal range 0..DEPTH-1
//   FWFT       read mode, 0 = registered read, 1 = fall-through
//
// Ports:
//   ck       in   clock; every state change happens on the rising edge
//   rst      in   synchronous active-low reset
//   Din      in   write data
//   Wen      in   write request
//   Ren      in   read request (pop)
//   Clr_err  in   clears Ovf and Udf (a set in the same cycle wins)
//   Dout     out  read data
//   Dvalid   out  Dout holds valid data
//   Fempty   out  FIFO empty
//   Ffull    out  FIFO full
//   Fafull   out  almost full
//   Faempty  out  almost empty
//   Count    out  occupancy, 0..DEPTH
//   Ovf      out  sticky overflow: write attempted while full
//   Udf      out  sticky underflow: read attempted while empty
// -----------------------------------------------------------------------------
module fifo_param #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 4,
  parameter int FWFT       = 0
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      Din,
  input  logic                  Wen,
  input  logic                  Ren,
  input  logic                  Clr_err,
  output logic [WIDTH-1:0]      Dout,
  output logic                  Dvalid,
  output logic                  Fempty,
  output logic                  Ffull,
  output logic                  Fafull,
  output logic                  Faempty,
  output logic [DEPTH_LOG2:0]   Count,
  output logic                  Ovf,
  output logic                  Udf
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef logic [CW-1:0]         count_t;
  typedef logic [DEPTH_LOG2-1:0] ptr_t;

  localparam count_t DEPTH_C = count_t'(DEPTH);
  localparam count_t AF_C    = count_t'(AF_LEVEL);
  localparam count_t AE_C    = count_t'(AE_LEVEL);
  localparam count_t ONE_C   = count_t'(1);
  localparam ptr_t   PONE_C  = ptr_t'(1);

  // ---------------------------------------------------------------------------
  // Storage and state
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem [DEPTH];

  ptr_t   wptr;
  ptr_t   rptr;
  count_t count;
  count_t count_next;

  logic fempty_q;
  logic ffull_q;
  logic fafull_q;
  logic faempty_q;
  logic ovf_q;
  logic udf_q;

  logic wr_ok;
  logic rd_ok;

  // Acceptance is decided from the flags registered before the edge, so a
  // write into a full FIFO is rejected even if a read frees a slot on the
  // same edge, and a read from an empty FIFO is rejected even if a write
  // lands on that edge.
  assign wr_ok = Wen & ~ffull_q;
  assign rd_ok = Ren & ~fempty_q;

  // ---------------------------------------------------------------------------
  // Next occupancy
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    count_next = count;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_next = count + ONE_C;
      2'b01:   count_next = count - ONE_C;
      default: count_next = count;  // idle, or a simultaneous push and pop
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pointers, count, status flags and error flags
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others regardless of the
  // order of the statements.
  always_ff @(posedge ck) begin
    if (!rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      fempty_q  <= 1'b1;
      ffull_q   <= 1'b0;
      fafull_q  <= 1'b0;
      faempty_q <= 1'b1;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      // The pointers are exactly DEPTH_LOG2 bits wide, so they wrap
      // modulo DEPTH on their own. When Wptr == Rptr, full and empty are
      // told apart only by count.
      if (wr_ok) wptr <= wptr + PONE_C;
      if (rd_ok) rptr <= rptr + PONE_C;

      count <= count_next;

      // The flags are registered from the next count, so they always agree
      // with the Count value that becomes visible on the same edge.
      fempty_q  <= (count_next == '0);
      ffull_q   <= (count_next == DEPTH_C);
      fafull_q  <= (count_next >= AF_C);
      faempty_q <= (count_next <= AE_C);

      // The error flags are sticky. A new error in the same cycle as
      // Clr_err wins, so no event can be lost to a concurrent clear.
      if (Wen && ffull_q) begin
        ovf_q <= 1'b1;
      end else if (Clr_err) begin
        ovf_q <= 1'b0;
      end

      if (Ren && fempty_q) begin
        udf_q <= 1'b1;
      end else if (Clr_err) begin
        udf_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory write port
  // ---------------------------------------------------------------------------
  // NOTE: the array is deliberately not reset. Clearing the pointers and the
  // count is enough to discard stale contents, and a reset on the array
  // would stop it mapping onto RAM.
  always_ff @(posedge ck) begin
    if (rst && wr_ok) begin
      mem[wptr] <= Din;
    end
  end

  // ---------------------------------------------------------------------------
  // Read port
  // ---------------------------------------------------------------------------
  generate
    if (FWFT == 0) begin : g_registered_read
      logic [WIDTH-1:0] dout_q;
      logic             dvalid_q;

      // Dout keeps its last value between reads. Dvalid marks only the
      // cycle that immediately follows an accepted read.
      always_ff @(posedge ck) begin
        if (!rst) begin
          dout_q   <= '0;
          dvalid_q <= 1'b0;
        end else begin
          dvalid_q <= rd_ok;
          if (rd_ok) begin
            dout_q <= mem[rptr];
          end
        end
      end

      assign Dout   = dout_q;
      assign Dvalid = dvalid_q;
    end else begin : g_fall_through
      // The head entry is presented combinationally. A word written on one
      // edge is visible right after that edge, because Fempty clears on the
      // same edge. A pop advances Rptr, so the next word appears after the
      // popping edge.
      assign Dout   = mem[rptr];
      assign Dvalid = ~fempty_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign Fempty  = fempty_q;
  assign Ffull   = ffull_q;
  assign Fafull  = fafull_q;
  assign Faempty = faempty_q;
  assign Count   = count;
  assign Ovf     = ovf_q;
  assign Udf     = udf_q;

endmodule

// File: tb/tb_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_fifo_param
//
// Self-checking bench for fifo_param. Two instances share one stimulus
// stream: one uses registered read (FWFT=0) and the other uses
// first-word-fall-through (FWFT=1). Because the stimulus is shared, occupancy
// and flags are checked on both instances, while the read-data behaviour is
// checked per mode.
// -----------------------------------------------------------------------------
module tb_fifo_param;

  logic       ck = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       wen;
  logic       ren;
  logic       clr_err;

  // Outputs of the registered-read instance.
  logic [7:0] dout0;
  logic       dvalid0, fempty0, ffull0, fafull0, faempty0, ovf0, udf0;
  logic [4:0] count0;

  // Outputs of the fall-through instance.
  logic [7:0] dout1;
  logic       dvalid1, fempty1, ffull1, fafull1, faempty1, ovf1, udf1;
  logic [4:0] count1;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 ck = ~ck;

  fifo_param #(.WIDTH(8), .DEPTH_LOG2(4), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(0)) u_reg (
    .ck(ck), .rst(rst), .Din(din), .Wen(wen), .Ren(ren), .Clr_err(clr_err),
    .Dout(dout0), .Dvalid(dvalid0), .Fempty(fempty0), .Ffull(ffull0),
    .Fafull(fafull0), .Faempty(faempty0), .Count(count0), .Ovf(ovf0), .Udf(udf0)
  );

  fifo_param #(.WIDTH(8), .DEPTH_LOG2(4), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1)) u_fwft (
    .ck(ck), .rst(rst), .Din(din), .Wen(wen), .Ren(ren), .Clr_err(clr_err),
    .Dout(dout1), .Dvalid(dvalid1), .Fempty(fempty1), .Ffull(ffull1),
    .Fafull(fafull1), .Faempty(faempty1), .Count(count1), .Ovf(ovf1), .Udf(udf1)
  );

  // Flag vectors are packed as {Fempty, Ffull, Fafull, Faempty, Ovf, Udf}.
  function automatic logic [5:0] flags0();
    return {fempty0, ffull0, fafull0, faempty0, ovf0, udf0};
  endfunction

  function automatic logic [5:0] flags1();
    return {fempty1, ffull1, fafull1, faempty1, ovf1, udf1};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of stimulus, then returns 1 time unit after the edge so
  // that the caller samples settled outputs.
  task automatic step(input logic w, input logic r, input logic [7:0] d, input logic c);
    wen     = w;
    ren     = r;
    din     = d;
    clr_err = c;
    @(posedge ck);
    #1;
    wen     = 1'b0;
    ren     = 1'b0;
    clr_err = 1'b0;
  endtask

  // Checks the count and the flags on both instances.
  task automatic check_status(input string tag, input logic [4:0] c, input logic [5:0] f);
    check({tag, ".count"},      {27'd0, count0}, {27'd0, c});
    check({tag, ".flags"},      {26'd0, flags0()}, {26'd0, f});
    check({tag, ".count_fwft"}, {27'd0, count1}, {27'd0, c});
    check({tag, ".flags_fwft"}, {26'd0, flags1()}, {26'd0, f});
  endtask

  typedef struct {
    logic       wen;
    logic       ren;
    logic [7:0] din;
    logic [4:0] count;
    logic [5:0] flags;
    logic       dvalid;
    logic [7:0] dout;
    logic       fvalid;
    logic [7:0] fdout;
  } vec_t;

  vec_t vecs[32];

  // Reference queue model for the random phase.
  logic [7:0] q[$];
  logic       m_ovf, m_udf;

  initial begin
    rst     = 1'b0;
    wen     = 1'b0;
    ren     = 1'b0;
    clr_err = 1'b0;
    din     = 8'h00;

    // ---------------- Reset, then idle for 5 cycles --------------------------
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_status("idle", 5'd0, 6'b100100);
      check("idle.dvalid",      {31'd0, dvalid0}, 32'd0);
      check("idle.dout",        {24'd0, dout0}, 32'd0);
      check("idle.dvalid_fwft", {31'd0, dvalid1}, 32'd0);
      step(0, 0, 8'h00, 0);
    end

    // ---------------- Table: write 0x01..0x10, then read 16 ------------------
    for (int i = 0; i < 16; i++) begin
      int n;
      n = i + 1;
      vecs[i].wen    = 1'b1;
      vecs[i].ren    = 1'b0;
      vecs[i].din    = 8'(i + 1);
      vecs[i].count  = 5'(n);
      vecs[i].flags  = {1'b0, n == 16, n >= 12, n <= 4, 2'b00};
      vecs[i].dvalid = 1'b0;
      vecs[i].dout   = 8'h00;
      vecs[i].fvalid = 1'b1;
      vecs[i].fdout  = 8'h01;
    end
    for (int j = 1; j <= 16; j++) begin
      int n;
      n = 16 - j;
      vecs[15 + j].wen    = 1'b0;
      vecs[15 + j].ren    = 1'b1;
      vecs[15 + j].din    = 8'h00;
      vecs[15 + j].count  = 5'(n);
      vecs[15 + j].flags  = {n == 0, 1'b0, n >= 12, n <= 4, 2'b00};
      vecs[15 + j].dvalid = 1'b1;
      vecs[15 + j].dout   = 8'(j);
      vecs[15 + j].fvalid = (n != 0);
      vecs[15 + j].fdout  = 8'(j + 1);
    end
    for (int k = 0; k < 32; k++) begin
      step(vecs[k].wen, vecs[k].ren, vecs[k].din, 0);
      check_status($sformatf("vec%0d", k), vecs[k].count, vecs[k].flags);
      check($sformatf("vec%0d.dvalid", k), {31'd0, dvalid0}, {31'd0, vecs[k].dvalid});
      if (vecs[k].dvalid) check($sformatf("vec%0d.dout", k), {24'd0, dout0}, {24'd0, vecs[k].dout});
      check($sformatf("vec%0d.fvalid", k), {31'd0, dvalid1}, {31'd0, vecs[k].fvalid});
      if (vecs[k].fvalid) check($sformatf("vec%0d.fdout", k), {24'd0, dout1}, {24'd0, vecs[k].fdout});
    end

    // ---------------- Overflow at full, then clear ---------------------------
    for (int i = 0; i < 16; i++) step(1, 0, 8'(8'h20 + i), 0);
    check_status("refill", 5'd16, 6'b011000);
    step(1, 0, 8'hAA, 0);
    check_status("ovf", 5'd16, 6'b011010);
    step(1, 0, 8'hAB, 1);   // a new error and a clear in the same cycle
    check_status("ovf_set_wins", 5'd16, 6'b011010);
    step(0, 0, 8'h00, 1);
    check_status("ovf_clr", 5'd16, 6'b011000);

    // ---------------- Simultaneous write and read at full -------------------
    step(1, 1, 8'hBB, 0);
    check_status("full_wr_rd", 5'd15, 6'b001010);
    check("full_wr_rd.dvalid", {31'd0, dvalid0}, 32'd1);
    check("full_wr_rd.dout",   {24'd0, dout0}, 32'h20);
    check("full_wr_rd.fdout",  {24'd0, dout1}, 32'h21);
    // Drain the rest: 0x21..0x2F and no 0xAA or 0xBB.
    for (int i = 1; i < 16; i++) begin
      step(0, 1, 8'h00, 0);
      check($sformatf("drain%0d.dout", i), {24'd0, dout0}, 32'(8'h20 + i));
      check($sformatf("drain%0d.dvalid", i), {31'd0, dvalid0}, 32'd1);
    end
    check_status("drained", 5'd0, 6'b100110);
    step(0, 0, 8'h00, 1);

    // ---------------- Simultaneous write and read at empty ------------------
    step(1, 1, 8'h77, 0);
    check_status("empty_wr_rd", 5'd1, 6'b000101);
    check("empty_wr_rd.dvalid",      {31'd0, dvalid0}, 32'd0);
    check("empty_wr_rd.dvalid_fwft", {31'd0, dvalid1}, 32'd1);
    check("empty_wr_rd.fdout",       {24'd0, dout1}, 32'h77);
    step(0, 1, 8'h00, 1);
    check_status("udf_clr_pop", 5'd0, 6'b100100);
    check("udf_clr_pop.dout", {24'd0, dout0}, 32'h77);

    // ---------------- Fall-through sequence ---------------------------------
    rst = 1'b0;
    step(0, 0, 8'h00, 0);
    rst = 1'b1;
    step(1, 0, 8'h5A, 0);
    check("fwft1.dvalid", {31'd0, dvalid1}, 32'd1);
    check("fwft1.dout",   {24'd0, dout1}, 32'h5A);
    step(1, 0, 8'h3C, 0);
    check("fwft2.dout",   {24'd0, dout1}, 32'h5A);
    step(0, 1, 8'h00, 0);
    check("fwft3.dout",   {24'd0, dout1}, 32'h3C);
    check("fwft3.dvalid", {31'd0, dvalid1}, 32'd1);
    step(0, 1, 8'h00, 0);
    check("fwft4.fempty", {31'd0, fempty1}, 32'd1);
    check("fwft4.dvalid", {31'd0, dvalid1}, 32'd0);

    // ---------------- Reset in the middle of a fill -------------------------
    for (int i = 0; i < 3; i++) step(1, 0, 8'(i + 1), 0);
    check_status("prefill", 5'd3, 6'b000100);
    rst = 1'b0;
    step(1, 0, 8'h09, 0);
    rst = 1'b1;
    check_status("midreset", 5'd0, 6'b100100);
    check("midreset.dvalid",      {31'd0, dvalid0}, 32'd0);
    check("midreset.dout",        {24'd0, dout0}, 32'd0);
    check("midreset.dvalid_fwft", {31'd0, dvalid1}, 32'd0);

    // ---------------- Random traffic against a queue model ------------------
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 8'(8'hC0 + i), 0);
      q.push_back(8'(8'hC0 + i));
    end
    check_status("fill8", 5'd8, 6'b000000);
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic       w, r, c, full, empty, rd;
      logic [7:0] d, exp_d;
      int         sz;
      w     = 1'($urandom_range(0, 1));
      r     = 1'($urandom_range(0, 1));
      c     = ($urandom_range(0, 31) == 0);
      d     = 8'($urandom);
      full  = (q.size() == 16);
      empty = (q.size() == 0);
      rd    = r && !empty;
      exp_d = 8'h00;
      step(w, r, d, c);
      if (rd) exp_d = q.pop_front();
      if (w && !full) q.push_back(d);
      if (w && full) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
      if (r && empty) m_udf = 1'b1; else if (c) m_udf = 1'b0;
      sz = q.size();
      check_status($sformatf("rnd%0d", cyc), 5'(sz),
                   {sz == 0, sz == 16, sz >= 12, sz <= 4, m_ovf, m_udf});
      check($sformatf("rnd%0d.dvalid", cyc), {31'd0, dvalid0}, {31'd0, rd});
      if (rd) check($sformatf("rnd%0d.dout", cyc), {24'd0, dout0}, {24'd0, exp_d});
      check($sformatf("rnd%0d.dvalid_fwft", cyc), {31'd0, dvalid1}, {31'd0, sz != 0});
      if (sz != 0) check($sformatf("rnd%0d.dout_fwft", cyc), {24'd0, dout1}, {24'd0, q[0]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised synchronous single-clock FIFO; the next generation of the team's 16x8 FIFO.
- Generalises data width and depth.
- Adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and an optional first-word-fall-through (FWFT) read mode.
- Sits between producer and consumer datapath stages in the same clock domain.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH_LOG2, 4, log2 of entry count; DEPTH = 2**DEPTH_LOG2 (default 16).
- AF_LEVEL, 12, Fafull asserted when Count >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 4, Faempty asserted when Count <= AE_LEVEL; legal range 0..DEPTH-1.
- FWFT, 0, 0 = registered-read mode; 1 = first-word-fall-through mode.

Ports:
- ck  input  1  clock; all state changes on posedge.
- rst  input  1  reset, synchronous, active-low.
- Din  input  WIDTH  write data.
- Wen  input  1  write request.
- Ren  input  1  read request (pop).
- Clr_err  input  1  clears Ovf/Udf.
- Dout  output  WIDTH  read data.
- Dvalid  output  1  Dout holds valid data.
- Fempty  output  1  FIFO empty.
- Ffull  output  1  FIFO full.
- Fafull  output  1  almost full.
- Faempty  output  1  almost empty.
- Count  output  DEPTH_LOG2+1  occupancy, 0..DEPTH.
- Ovf  output  1  sticky overflow: write attempted while full.
- Udf  output  1  sticky underflow: read attempted while empty.

Behaviour:
- Reset (rst==0 at posedge) values:
  - Wptr, Rptr, Count = 0; Fempty = 1; Ffull = 0; Fafull = 0; Faempty = 1; Ovf = Udf = 0.
  - Dout = 0 and Dvalid = 0 in FWFT=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data; the FIFO is empty on the next cycle.
- Acceptance uses the flags registered before the edge:
  - rd_ok = Ren & ~Fempty.
  - wr_ok = Wen & ~Ffull.
- Write: on wr_ok, mem[Wptr] <= Din; Wptr increments modulo DEPTH, wrapping naturally through the DEPTH_LOG2-bit pointer.
- Read, FWFT=0:
  - On rd_ok, Dout <= mem[Rptr]; Rptr increments; Dvalid = 1 for exactly the following cycle.
  - Otherwise Dvalid = 0 and Dout holds its last value.
  - Latency from write to first readable: 1 cycle (Fempty deasserts the cycle after the write).
- Read, FWFT=1:
  - Dout = mem[Rptr] continuously; Dvalid = ~Fempty.
  - On rd_ok, Rptr increments and the next word appears on Dout after the edge.
  - The head word is visible the cycle after it is written.
- Count update: Count + wr_ok - rd_ok, i.e. +1, -1 or unchanged when both are accepted.
- Flags are registered from the next Count value:
  - Fempty = (Count==0).
  - Ffull = (Count==DEPTH).
  - Fafull = (Count >= AF_LEVEL).
  - Faempty = (Count <= AE_LEVEL).
- Simultaneous Wen & Ren:
  - Neither full nor empty: both accepted, Count unchanged, flags unchanged.
  - When full: read accepted, write rejected; Count becomes DEPTH-1, Ffull clears, Ovf sets.
  - When empty: write accepted, read rejected; Count becomes 1, Fempty clears, Udf sets; in FWFT=0 Dvalid stays 0.
- Errors:
  - Ovf sets on Wen & Ffull; Udf sets on Ren & Fempty.
  - Both are cleared by Clr_err; a set in the same cycle wins over the clear.
  - Rejected operations change no pointers, data or Count.
- Pointer wrap: full and empty with Wptr==Rptr are distinguished solely by Count.

Test Plan:
- Reset, then idle 5 cycles -> Fempty=1, Faempty=1, Count=0, Dvalid=0, Ovf=Udf=0.
- Write 0x01..0x10 over 16 cycles, then read 16 (FWFT=0) -> Dout sequence 0x01..0x10, each one cycle after its Ren, with Dvalid high.
  - Fafull rises when Count reaches 12; Ffull rises at 16; Faempty clears when Count reaches 5.
- At full, assert Wen=1 with Din=0xAA -> Count stays 16, Ovf=1, 0xAA never read back.
  - Then pulse Clr_err -> Ovf=0.
- At full, assert Wen=Ren=1 -> read accepted, write dropped, Count=15, Ffull=0, Ovf=1.
  - At empty, assert Wen=Ren=1 -> Count=1, Udf=1, Dvalid=0.
- Fill to 8, then alternate random Wen/Ren/both for 10000 cycles against a reference queue model -> Dout, flags and Count match every cycle; pointers wrap at least 100 times.
- FWFT=1: write 0x5A, 0x3C -> Dout=0x5A with Dvalid=1 one cycle after the first write.
  - Ren for one cycle -> Dout=0x3C; Ren again -> Fempty=1, Dvalid=0.
  - Assert rst=0 mid-fill -> Count=0 next cycle.
